// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM and scan-result types plus lock-function key codes for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, OUTPUT, HELD} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_t;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam logic [3:0] KEY_CLEAR = 4'hD;
  localparam logic [3:0] KEY_SETPW = 4'hE;
  localparam logic [3:0] KEY_SPARE = 4'hF;
endpackage

// File: rtl/keypad_row_scan.sv
// keypad_row_scan: row divider/drive, 2-flop column sync, per-scan NONE/SINGLE/MULTI classification with scan_tick, result, code
module keypad_row_scan import keypad_pkg::*; #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       scan_tick,
  output scan_t      result,
  output logic [3:0] code
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [DW-1:0] div;
  logic [1:0] row, col_idx;
  logic [3:0] sync0, sync1, low, acc_code;
  logic last, hit, row_multi, acc_any, acc_multi, any_now, multi_now;
  assign last = div == DW'(SCAN_DIV - 1);
  assign low = ~sync1;
  assign hit = |low;
  assign row_multi = |(low & (low - 4'd1));
  assign col_idx = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
  assign any_now = acc_any | hit;
  assign multi_now = acc_multi | row_multi | (acc_any & hit);
  assign row_out = ~(4'b0001 << row);
  always_ff @(posedge clk) begin
    if (!rst) begin
      div <= '0;
      row <= '0;
      sync0 <= '1;
      sync1 <= '1;
      acc_any <= 1'b0;
      acc_multi <= 1'b0;
      acc_code <= '0;
      scan_tick <= 1'b0;
      result <= NONE;
      code <= '0;
    end else begin
      sync0 <= col_in;
      sync1 <= sync0;
      div <= last ? '0 : div + DW'(1);
      scan_tick <= last && row == 2'd3;
      if (last) begin
        row <= row + 2'd1;
        acc_any <= row != 2'd3 && any_now;
        acc_multi <= row != 2'd3 && multi_now;
        acc_code <= hit ? {row, col_idx} : acc_code;
        if (row == 2'd3) begin
          result <= multi_now ? MULTI : any_now ? SINGLE : NONE;
          code <= hit ? {row, col_idx} : acc_code;
        end
      end
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: debounced 4x4 keypad front end, one valid/ready key event per press; KEYPAD_AUTOREPEAT_EN adds auto-repeat
module keypad_scanner import keypad_pkg::*; #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_SCANS = 5
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY = 125
  , parameter int REPEAT_RATE = 25
`endif
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_out,
  input  logic [3:0] col_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down
);
  localparam logic [7:0] DB = 8'(DEBOUNCE_SCANS);
  state_t state, state_n;
  scan_t result;
  logic scan_tick, match;
  logic [3:0] code, cand, cand_n;
  logic [7:0] cnt, cnt_n, rel_cnt, rel_n;
  keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk),
    .rst(rst),
    .col_in(col_in),
    .row_out(row_out),
    .scan_tick(scan_tick),
    .result(result),
    .code(code)
  );
  assign match = scan_tick && result == SINGLE && code == cand;
  assign key_valid = state == OUTPUT;
  assign key_code = cand;
  assign key_down = state == OUTPUT || state == HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] RD = 8'(REPEAT_DELAY);
  localparam logic [7:0] RR = 8'(REPEAT_RATE);
  logic [7:0] hold, hold_n;
  logic rep, rep_n, rep_hit;
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold <= '0;
      rep <= 1'b0;
    end else begin
      hold <= hold_n;
      rep <= rep_n;
    end
  end
  always_comb begin
    hold_n = hold;
    rep_n = rep;
    rep_hit = 1'b0;
    if (state == IDLE || state == DEBOUNCE) begin
      hold_n = '0;
      rep_n = 1'b0;
    end else if (scan_tick) begin
      hold_n = match ? hold + 8'd1 : '0;
      rep_n = match & rep;
      if (match && hold_n == (rep ? RR : RD)) begin
        hold_n = '0;
        rep_n = 1'b1;
        rep_hit = state == HELD;
      end
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cand <= '0;
      cnt <= '0;
      rel_cnt <= '0;
    end else begin
      state <= state_n;
      cand <= cand_n;
      cnt <= cnt_n;
      rel_cnt <= rel_n;
    end
  end
  always_comb begin
    state_n = state;
    cand_n = cand;
    cnt_n = cnt;
    rel_n = rel_cnt;
    case (state)
      IDLE: if (scan_tick && result == SINGLE) begin
        cand_n = code;
        cnt_n = 8'd1;
        rel_n = '0;
        state_n = DB == 8'd1 ? OUTPUT : DEBOUNCE;
      end
      DEBOUNCE: if (scan_tick) begin
        cnt_n = cnt + 8'd1;
        state_n = !match ? IDLE : cnt_n == DB ? OUTPUT : DEBOUNCE;
      end
      OUTPUT: state_n = key_ready ? HELD : OUTPUT;
      HELD: state_n = rel_cnt == DB ? IDLE : HELD;
      default: state_n = IDLE;
    endcase
    if ((state == OUTPUT || state == HELD) && scan_tick)
      rel_n = result != NONE ? '0 : rel_cnt == DB ? rel_cnt : rel_cnt + 8'd1;
`ifdef KEYPAD_AUTOREPEAT_EN
    if (rep_hit && state_n == HELD) state_n = OUTPUT;
`endif
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a behavioural 4x4 keypad matrix
module tb_keypad_scanner;
  logic clk = 1'b0, rst = 1'b0, key_ready = 1'b0;
  logic [3:0] row_out, col_in, key_code;
  logic key_valid, key_down;
  logic [15:0] keys = '0;
  logic [3:0] sb[$];
  int vectors = 0, miscompares = 0, events = 0, valid_cycles = 0, e0, v0;
  always #5 clk = ~clk;
  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3)
`ifdef KEYPAD_AUTOREPEAT_EN
    , .REPEAT_DELAY(6)
    , .REPEAT_RATE(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .row_out(row_out),
    .col_in(col_in),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_down(key_down)
  );
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst) begin
    if (key_valid) valid_cycles++;
    if (key_valid && key_ready) begin
      events++;
      chk("sb_pending", sb.size() != 0, 1);
      if (sb.size() != 0) chk("evt_code", key_code, sb.pop_front());
    end
  end
  task automatic scans(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!dut.u_scan.scan_tick && t < 40);
      chk("scan_tick", dut.u_scan.scan_tick, 1);
    end
  endtask
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 key_ready = v;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row", row_out, 4'hE);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_down", key_down, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    set_ready(1'b1);
    scans(1);
    e0 = events;
    keys = 16'h1 << 6;
    scans(2);
    chk("t1_deb_down", key_down, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    keys = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_row", row_out, 4'hE);
    chk("t1_valid", key_valid, 0);
    chk("t1_code", key_code, 0);
    chk("t1_down", key_down, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    scans(4);
    chk("t1_events", events - e0, 0);
    e0 = events;
    keys = 16'h1 << 6;
    sb.push_back(4'h6);
    scans(3);
    @(negedge clk);
    chk("t2_valid", key_valid, 1);
    chk("t2_code", key_code, 4'h6);
    scans(7);
    chk("t2_down_press", key_down, 1);
    keys = '0;
    scans(2);
    chk("t2_down_held", key_down, 1);
    scans(2);
    chk("t2_down_clear", key_down, 0);
    chk("t2_events", events - e0, 1);
    set_ready(1'b0);
    scans(1);
    e0 = events;
    keys = 16'h1 << 9;
    sb.push_back(4'h9);
    scans(5);
    keys = '0;
    for (int i = 0; i < 10; i++) begin
      scans(1);
      chk("t3_valid", key_valid, 1);
      chk("t3_code", key_code, 4'h9);
    end
    chk("t3_wait_events", events - e0, 0);
    set_ready(1'b1);
    repeat (4) @(negedge clk);
    chk("t3_valid_clear", key_valid, 0);
    chk("t3_down", key_down, 0);
    chk("t3_events", events - e0, 1);
    scans(1);
    e0 = events;
    v0 = valid_cycles;
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h1 << 3 : 16'h0;
      scans(1);
    end
    keys = '0;
    scans(4);
    chk("t4_valid_cycles", valid_cycles - v0, 0);
    chk("t4_events", events - e0, 0);
    e0 = events;
    keys = 16'h0021;
    scans(6);
    chk("t5_multi_events", events - e0, 0);
    chk("t5_multi_down", key_down, 0);
    keys = 16'h0001;
    sb.push_back(4'h0);
    scans(3);
    @(negedge clk);
    chk("t5_valid", key_valid, 1);
    chk("t5_code", key_code, 4'h0);
    keys = '0;
    scans(5);
    chk("t5_events", events - e0, 1);
    chk("t5_down", key_down, 0);
    e0 = events;
    keys = 16'h1 << 10;
    sb.push_back(4'hA);
`ifdef KEYPAD_AUTOREPEAT_EN
    repeat (4) sb.push_back(4'hA);
`endif
    scans(15);
    keys = '0;
    scans(5);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("t6_events", events - e0, 5);
`else
    chk("t6_events", events - e0, 1);
`endif
    chk("t6_down", key_down, 0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
